// File: rtl/fire_seq_pkg.sv
// Shared types and constants for the fire sequencer.
//   state_e     : sequencer state encoding
//   ARM_CYCLES  : cycles spent in ARM with onYourMark high before GO
//   SPAN_MARGIN : extra WAIT cycles added on top of the longest channel span
//   DEF_*       : default widths and channel count
package fire_seq_pkg;

  localparam int unsigned DEF_NUM_CH  = 8;
  localparam int unsigned DEF_PD_W    = 16;
  localparam int unsigned DEF_CT_W    = 9;
  localparam int unsigned DEF_TO_W    = 12;

  localparam int unsigned ARM_CYCLES  = 2;
  localparam int unsigned SPAN_MARGIN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StFire,
    StWait,
    StRelease,
    StFault
  } state_e;

endpackage

// File: rtl/fire_span_max.sv
// Combinational maximum of (phase delay + charge time) over the enabled channels.
//   pd   : flattened phase delays, channel i at [i*PD_W +: PD_W]
//   ct   : flattened charge times, channel i at [i*CT_W +: CT_W]
//   en   : channel-enable mask; disabled channels do not contribute
//   span : max over enabled channels of pd+ct, PD_W+1 bits (0 if none enabled)
module fire_span_max
  import fire_seq_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned PD_W   = DEF_PD_W,
  parameter int unsigned CT_W   = DEF_CT_W
) (
  input  logic [NUM_CH*PD_W-1:0] pd,
  input  logic [NUM_CH*CT_W-1:0] ct,
  input  logic [NUM_CH-1:0]      en,
  output logic [PD_W:0]          span
);

  localparam int unsigned SpanW = PD_W + 1;

  logic [PD_W:0] sum;

  always_comb begin
    span = '0;
    sum  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // One extra bit keeps the sum exact for any CT_W <= PD_W.
      sum = SpanW'(pd[i*PD_W +: PD_W]) + SpanW'(ct[i*CT_W +: CT_W]);
      if (en[i] && (sum > span)) begin
        span = sum;
      end
    end
  end

endmodule

// File: rtl/fire_sequencer.sv
// Upstream controller for a bank of transducer channels: holds per-channel timing,
// runs the arm/go handshake on a trigger, and reports done or a sticky fault.
//   clk, rst          : clock, synchronous active-low reset
//   cfg_we/addr/pd/ct : timing register write (accepted only in IDLE or FAULT)
//   cfg_en            : channel-enable mask, sampled on trig
//   trig, clear       : fire request pulse, sticky-fault clear
//   busy, done, fault : status; fault_ch names the offending enabled channels
//   ch_active/mark/go : channel handshake (isActive, onYourMark, GOGOGO_EXCLAMATION)
//   ch_pd, ch_ct      : flattened timing registers, channel i at [i*W +: W]
//   ch_fire_complete, ch_warning : per-channel status back from the channels
module fire_sequencer
  import fire_seq_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned PD_W   = DEF_PD_W,
  parameter int unsigned CT_W   = DEF_CT_W,
  parameter int unsigned TO_W   = DEF_TO_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
  input  logic [PD_W-1:0]           cfg_pd,
  input  logic [CT_W-1:0]           cfg_ct,
  input  logic [NUM_CH-1:0]         cfg_en,
  input  logic                      trig,
  input  logic                      clear,
  output logic                      busy,
  output logic                      done,
  output logic                      fault,
  output logic [NUM_CH-1:0]         fault_ch,
  output logic [NUM_CH-1:0]         ch_active,
  output logic                      ch_mark,
  output logic                      ch_go,
  output logic [NUM_CH*PD_W-1:0]    ch_pd,
  output logic [NUM_CH*CT_W-1:0]    ch_ct,
  input  logic [NUM_CH-1:0]         ch_fire_complete,
  input  logic [NUM_CH-1:0]         ch_warning
);

  localparam int unsigned SpanCntW = PD_W + 2;
  // Leaving WAIT when the counter is one short of all-ones makes the fault
  // visible in the very cycle the counter would read 2^TO_W-1.
  localparam logic [TO_W-1:0] ToLast = {{(TO_W-1){1'b1}}, 1'b0};

  logic [PD_W-1:0] pd_q [NUM_CH];
  logic [CT_W-1:0] ct_q [NUM_CH];

  state_e              state_q, state_d;
  logic [1:0]          arm_cnt_q, arm_cnt_d;
  logic [NUM_CH-1:0]   en_q, en_d;
  logic [PD_W:0]       span_q, span_d;
  logic [SpanCntW-1:0] span_cnt_q, span_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [NUM_CH-1:0]   fault_ch_q, fault_ch_d;
  logic                zdone_q, zdone_d;
  logic                cfg_open;
  logic [NUM_CH-1:0]   warn;
  logic [PD_W:0]       span_max;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pd_q[i] <= '0;
        ct_q[i] <= '0;
      end
    end else if (cfg_we && cfg_open) begin
      pd_q[cfg_addr] <= cfg_pd;
      ct_q[cfg_addr] <= cfg_ct;
    end
  end

  always_comb begin
    ch_pd = '0;
    ch_ct = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_pd[i*PD_W +: PD_W] = pd_q[i];
      ch_ct[i*CT_W +: CT_W] = ct_q[i];
    end
  end

  fire_span_max #(
    .NUM_CH (NUM_CH),
    .PD_W   (PD_W),
    .CT_W   (CT_W)
  ) u_span_max (
    .pd   (ch_pd),
    .ct   (ch_ct),
    .en   (en_q),
    .span (span_max)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      arm_cnt_q  <= '0;
      en_q       <= '0;
      span_q     <= '0;
      span_cnt_q <= '0;
      to_cnt_q   <= '0;
      fault_ch_q <= '0;
      zdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      en_q       <= en_d;
      span_q     <= span_d;
      span_cnt_q <= span_cnt_d;
      to_cnt_q   <= to_cnt_d;
      fault_ch_q <= fault_ch_d;
      zdone_q    <= zdone_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    en_d       = en_q;
    span_d     = span_q;
    span_cnt_d = span_cnt_q;
    to_cnt_d   = to_cnt_q;
    fault_ch_d = fault_ch_q;
    zdone_d    = 1'b0;
    busy       = 1'b0;
    done       = zdone_q;
    ch_active  = '0;
    ch_mark    = 1'b0;
    ch_go      = 1'b0;
    cfg_open   = 1'b0;
    warn       = ch_warning & en_q;

    unique case (state_q)
      StIdle: begin
        cfg_open = 1'b1;
        if (trig) begin
          if (cfg_en == '0) begin
            // Nothing to fire: report completion without leaving IDLE.
            zdone_d = 1'b1;
          end else begin
            en_d      = cfg_en;
            arm_cnt_d = '0;
            state_d   = StArm;
          end
        end
      end
      StArm: begin
        busy      = 1'b1;
        ch_active = en_q;
        ch_mark   = 1'b1;
        span_d    = span_max;
        if (arm_cnt_q == 2'(ARM_CYCLES - 1)) begin
          state_d = StFire;
        end else begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end
      end
      StFire: begin
        busy       = 1'b1;
        ch_active  = en_q;
        ch_mark    = 1'b1;
        ch_go      = 1'b1;
        span_cnt_d = {1'b0, span_q} + SpanCntW'(SPAN_MARGIN);
        to_cnt_d   = '0;
        state_d    = StWait;
      end
      StWait: begin
        busy      = 1'b1;
        ch_active = en_q;
        if (span_cnt_q != '0) begin
          span_cnt_d = span_cnt_q - SpanCntW'(1);
        end else if ((ch_fire_complete & en_q) == en_q) begin
          state_d = StRelease;
        end else if (to_cnt_q == ToLast) begin
          state_d    = StFault;
          fault_ch_d = en_q & ~ch_fire_complete;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      StRelease: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      StFault: begin
        cfg_open = 1'b1;
        if (clear) begin
          state_d    = StIdle;
          fault_ch_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A warning from any enabled channel aborts the fire, ahead of success.
    if ((state_q == StArm || state_q == StFire || state_q == StWait) && (warn != '0)) begin
      state_d    = StFault;
      fault_ch_d = warn;
    end
  end

  assign fault    = (state_q == StFault);
  assign fault_ch = fault_ch_q;

endmodule

// File: tb/tb_fire_sequencer.sv
// Scoreboard bench for fire_sequencer: stimulus pushes the expected done/fault
// event (kind, fault_ch, cycle) and a monitor pops and compares on each event.
module tb_fire_sequencer;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned PD_W   = 16;
  localparam int unsigned CT_W   = 9;
  localparam int unsigned TO_W   = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   cfg_we = 1'b0;
  logic [2:0]             cfg_addr = '0;
  logic [PD_W-1:0]        cfg_pd = '0;
  logic [CT_W-1:0]        cfg_ct = '0;
  logic [NUM_CH-1:0]      cfg_en = '0;
  logic                   trig = 1'b0;
  logic                   clear = 1'b0;
  logic                   busy, done, fault, ch_mark, ch_go;
  logic [NUM_CH-1:0]      fault_ch, ch_active;
  logic [NUM_CH*PD_W-1:0] ch_pd;
  logic [NUM_CH*CT_W-1:0] ch_ct;
  logic [NUM_CH-1:0]      ch_fire_complete = '0;
  logic [NUM_CH-1:0]      ch_warning = '0;

  fire_sequencer #(
    .NUM_CH (NUM_CH),
    .PD_W   (PD_W),
    .CT_W   (CT_W),
    .TO_W   (TO_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_pd           (cfg_pd),
    .cfg_ct           (cfg_ct),
    .cfg_en           (cfg_en),
    .trig             (trig),
    .clear            (clear),
    .busy             (busy),
    .done             (done),
    .fault            (fault),
    .fault_ch         (fault_ch),
    .ch_active        (ch_active),
    .ch_mark          (ch_mark),
    .ch_go            (ch_go),
    .ch_pd            (ch_pd),
    .ch_ct            (ch_ct),
    .ch_fire_complete (ch_fire_complete),
    .ch_warning       (ch_warning)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit                is_fault;
    logic [NUM_CH-1:0] fch;
    int                due;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input bit is_fault, input logic [NUM_CH-1:0] fch, input int due);
    exp_t e;
    e.is_fault = is_fault;
    e.fch      = fch;
    e.due      = due;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse or rising fault is matched against the scoreboard.
  task automatic got_event(input bit is_fault);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d, expected none",
               is_fault ? "fault" : "done", cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 64'(is_fault), 64'(e.is_fault));
      check("event_cycle", 64'(cyc), 64'(e.due));
      check("event_fault_ch", 64'(fault_ch), 64'(e.fch));
    end
  endtask

  logic fault_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (done) got_event(1'b0);
      if (fault && !fault_prev) got_event(1'b1);
    end
    fault_prev = fault;
  end

  // Channel model: completes pd+ct+1 cycles after GO if allowed by comp_mask.
  logic [NUM_CH-1:0] comp_mask = '1;
  int tb_pd [NUM_CH];
  int tb_ct [NUM_CH];
  int cnt   [NUM_CH];
  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!ch_active[i]) begin
        ch_fire_complete[i] = 1'b0;
        cnt[i] = 0;
      end else if (ch_go) begin
        cnt[i] = tb_pd[i] + tb_ct[i] + 1;
      end else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0 && comp_mask[i]) ch_fire_complete[i] = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic wr(input int ch, input int pd, input int ct);
    cfg_we = 1'b1; cfg_addr = 3'(ch); cfg_pd = PD_W'(pd); cfg_ct = CT_W'(ct);
    tb_pd[ch] = pd;
    tb_ct[ch] = ct;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic fire(input logic [NUM_CH-1:0] en);
    cfg_en = en;
    trig   = 1'b1;
    step();
    trig   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending events, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  int c;

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin tb_pd[i] = 0; tb_ct[i] = 0; cnt[i] = 0; end
    repeat (3) step();
    // Reset state
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_fault", 64'(fault), 0);
    check("rst_fault_ch", 64'(fault_ch), 0);
    check("rst_active", 64'(ch_active), 0);
    check("rst_mark_go", 64'({ch_mark, ch_go}), 0);
    check("rst_pd", 64'(ch_pd == '0), 1);
    rst = 1'b1;
    step();

    wr(0, 3, 5);
    wr(1, 10, 2);
    check("cfg_pd0", 64'(ch_pd[0 +: PD_W]), 3);
    check("cfg_pd1", 64'(ch_pd[PD_W +: PD_W]), 10);
    check("cfg_ct1", 64'(ch_ct[CT_W +: CT_W]), 2);

    // 1: basic fire, span = 12 -> WAIT c+4..c+18, RELEASE at c+19
    c = cyc;
    push(1'b0, '0, c + 19);
    fire(8'h03);
    check("t1_arm0", 64'({busy, ch_active, ch_mark, ch_go}), 64'({1'b1, 8'h03, 2'b10}));
    goto(c + 2);
    check("t1_arm1", 64'({ch_active, ch_mark, ch_go}), 64'({8'h03, 2'b10}));
    goto(c + 3);
    check("t1_fire", 64'({ch_active, ch_mark, ch_go}), 64'({8'h03, 2'b11}));
    goto(c + 4);
    check("t1_wait", 64'({ch_active, ch_mark, ch_go}), 64'({8'h03, 2'b00}));
    goto(c + 18);
    check("t1_wait_end", 64'({busy, done, ch_active}), 64'({2'b10, 8'h03}));
    goto(c + 19);
    check("t1_release", 64'({busy, ch_active}), 64'({1'b1, 8'h00}));
    goto(c + 20);
    check("t1_idle_busy", 64'(busy), 0);
    drain(10);

    // Zero enable mask: done next cycle, no busy
    c = cyc;
    push(1'b0, '0, c + 1);
    fire(8'h00);
    check("zero_en_busy", 64'(busy), 0);
    drain(5);

    // 2: masked channel, span = 8 -> done at c+15
    comp_mask = 8'h01;
    c = cyc;
    push(1'b0, '0, c + 15);
    fire(8'h01);
    check("t2_active", 64'(ch_active), 64'(8'h01));
    goto(c + 6);
    ch_warning = 8'h02;
    step();
    ch_warning = '0;
    drain(30);
    check("t2_no_fault", 64'(fault), 0);

    // 3: timeout, span_cnt zero at c+14, fault at c+29
    comp_mask = 8'h00;
    c = cyc;
    push(1'b1, 8'h01, c + 29);
    fire(8'h01);
    goto(c + 28);
    check("t3_pre_fault", 64'(fault), 0);
    goto(c + 29);
    check("t3_fault", 64'({fault, fault_ch, ch_active}), 64'({1'b1, 8'h01, 8'h00}));
    fire(8'h01);
    check("t3_trig_ignored", 64'({busy, fault}), 64'({1'b0, 1'b1}));
    pulse_clear();
    check("t3_cleared", 64'({fault, fault_ch}), 0);
    drain(5);

    // 4: warning 3 cycles into WAIT -> fault next cycle
    comp_mask = 8'hff;
    c = cyc;
    push(1'b1, 8'h02, c + 8);
    fire(8'h03);
    goto(c + 7);
    ch_warning = 8'h02;
    step();
    check("t4_fault", 64'({fault, fault_ch, ch_active, done}), 64'({1'b1, 8'h02, 8'h00, 1'b0}));
    pulse_clear();   // warning still high: clear wins
    ch_warning = '0;
    check("t4_cleared", 64'({fault, fault_ch, busy}), 0);
    drain(30);

    // 5: write and second trig during WAIT are ignored
    c = cyc;
    push(1'b0, '0, c + 19);
    fire(8'h03);
    goto(c + 6);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_pd = 16'd99; cfg_ct = 9'd7; trig = 1'b1;
    step();
    cfg_we = 1'b0; trig = 1'b0;
    goto(c + 20);
    check("t5_pd0_kept", 64'(ch_pd[0 +: PD_W]), 3);
    check("t5_ct0_kept", 64'(ch_ct[0 +: CT_W]), 5);
    repeat (30) step();
    drain(5);

    // 6: reset mid-fire
    c = cyc;
    fire(8'h03);
    goto(c + 6);
    rst = 1'b0;
    step();
    check("t6_outputs", 64'({busy, done, fault, fault_ch, ch_active, ch_mark, ch_go}), 0);
    check("t6_regs", 64'((ch_pd == '0) && (ch_ct == '0)), 1);
    rst = 1'b1;
    step();
    for (int i = 0; i < NUM_CH; i++) begin tb_pd[i] = 0; tb_ct[i] = 0; end
    wr(0, 3, 5);
    c = cyc;
    push(1'b0, '0, c + 15);
    fire(8'h01);
    check("t6_rerun_active", 64'(ch_active), 64'(8'h01));
    drain(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
